// File: rtl/insn_encoder.sv
// RV32I instruction assembler: builds words from decoded fields, tags each with a PC and queues them.
// Build option INSN_ENCODER_ILLEGAL_NOP_EN: unsupported opcodes enqueue a NOP instead of being dropped.
module insn_encoder #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [6:0]                 opcode_i,
    input  logic [4:0]                 rd_i,
    input  logic [4:0]                 rs1_i,
    input  logic [4:0]                 rs2_i,
    input  logic [2:0]                 funct3_i,
    input  logic [6:0]                 funct7_i,
    input  logic [4:0]                 shamt_i,
    input  logic [DWIDTH-1:0]          imm_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DWIDTH-1:0]          insn_o,
    output logic [AWIDTH-1:0]          pc_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       illegal_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       push_word;

    logic [DWIDTH-1:0] insn_mem [DEPTH];
    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [AWIDTH-1:0] pc_next;
    logic              illegal_q;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (opcode_i)
            OP_R:
                enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            OP_IMM: begin
                if (funct3_i == 3'b001 || funct3_i == 3'b101)
                    enc_word = {funct7_i, shamt_i, rs1_i, funct3_i, rd_i, opcode_i};
                else
                    enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            end
            OP_LOAD, OP_JALR:
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            OP_STORE:
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            OP_BRANCH:
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
            OP_LUI, OP_AUIPC:
                enc_word = {imm_i[31:12], rd_i, opcode_i};
            OP_JAL:
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default:
                enc_legal = 1'b0;
        endcase
    end

    assign ready_o = (count != CW'(DEPTH));
    assign valid_o = (count != '0);
    assign count_o = count;
    assign accept  = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

`ifdef INSN_ENCODER_ILLEGAL_NOP_EN
    assign push      = accept;
    assign push_word = enc_legal ? enc_word : 32'h00000013;
`else
    assign push      = accept && enc_legal;
    assign push_word = enc_word;
`endif

    // Storage carries no reset; the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            insn_mem[wr_ptr] <= DWIDTH'(push_word);
            pc_mem[wr_ptr]   <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pc_next   <= BASE_ADDR;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !enc_legal;
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                pc_next <= pc_next + AWIDTH'(4);
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign insn_o    = valid_o ? insn_mem[rd_ptr] : '0;
    assign pc_o      = valid_o ? pc_mem[rd_ptr]   : '0;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard bench for insn_encoder: directed field sets with hand-encoded words.
// A second instance with BASE_ADDR=32'hFFFFFFFC shares the stimulus to exercise PC wrap.
module tb_insn_encoder;

    localparam logic [31:0] WRAP_BASE = 32'hFFFFFFFC;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_i;
    logic [6:0]  opcode_i, funct7_i;
    logic [4:0]  rd_i, rs1_i, rs2_i, shamt_i;
    logic [2:0]  funct3_i;
    logic [31:0] imm_i;

    logic        ready_o, valid_o, illegal_o;
    logic [31:0] insn_o, pc_o;
    logic [2:0]  count_o;

    logic        ready_w, valid_w, illegal_w;
    logic [31:0] insn_w, pc_w;
    logic [2:0]  count_w;

    exp_t        sb[$];
    logic [31:0] exp_pc;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    insn_encoder #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .shamt_i(shamt_i), .imm_i(imm_i),
        .valid_o(valid_o), .ready_i(ready_i), .insn_o(insn_o), .pc_o(pc_o),
        .count_o(count_o), .illegal_o(illegal_o)
    );

    insn_encoder #(.AWIDTH(32), .DWIDTH(32), .DEPTH(4), .BASE_ADDR(WRAP_BASE)) dut_wrap (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_w),
        .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .shamt_i(shamt_i), .imm_i(imm_i),
        .valid_o(valid_w), .ready_i(ready_i), .insn_o(insn_w), .pc_o(pc_w),
        .count_o(count_w), .illegal_o(illegal_w)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one field set; hold it until ready_o is seen, then log the expected head entry.
    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] sh, input logic [31:0] imm,
                                 input logic [31:0] exp_insn, input bit legal);
        int n = 0;
        opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; shamt_i = sh; imm_i = imm;
        valid_i  = 1'b1;
        while (!ready_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) begin
            total++; bad++;
            $display("[TB] FAIL ready_timeout: ready_o stayed %b, required 1", ready_o);
            valid_i = 1'b0;
        end else begin
            if (legal) begin
                sb.push_back('{insn: exp_insn, pc: exp_pc});
                exp_pc = exp_pc + 32'd4;
            end else begin
`ifdef INSN_ENCODER_ILLEGAL_NOP_EN
                sb.push_back('{insn: 32'h00000013, pc: exp_pc});
                exp_pc = exp_pc + 32'd4;
`endif
            end
            @(posedge clk); #1;
            valid_i = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((count_o != 3'd0 || sb.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_count", 32'(count_o), 32'd0);
        checkOutput("drain_scoreboard", 32'(sb.size()), 32'd0);
    endtask

    // Reset lands between edges; outputs must clear before the next edge arrives.
    task automatic pulseReset();
        @(posedge clk); #3;
        rst = 1'b1;
        sb.delete();
        exp_pc = 32'h0;
        #1;
        checkOutput("rst_valid", 32'(valid_o), 32'd0);
        checkOutput("rst_count", 32'(count_o), 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd1);
        checkOutput("rst_insn", insn_o, 32'd0);
        checkOutput("rst_pc", pc_o, 32'd0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL unexpected_pop: got insn %h pc %h, required no output", insn_o, pc_o);
            end else begin
                e = sb.pop_front();
                checkOutput("insn", insn_o, e.insn);
                checkOutput("pc", pc_o, e.pc);
                checkOutput("wrap_insn", insn_w, e.insn);
                checkOutput("wrap_pc", pc_w, e.pc + WRAP_BASE);
            end
        end
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        funct3_i = '0; funct7_i = '0; shamt_i = '0; imm_i = '0;
        exp_pc = 32'h0;
        #2;
        checkOutput("reset_count", 32'(count_o), 32'd0);
        checkOutput("reset_valid", 32'(valid_o), 32'd0);
        checkOutput("reset_ready", 32'(ready_o), 32'd1);
        checkOutput("reset_illegal", 32'(illegal_o), 32'd0);
        checkOutput("reset_insn", insn_o, 32'd0);
        checkOutput("reset_pc", pc_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] format round-trip");
        ready_i = 1'b1;
        applyStimulus(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 5'd0, 32'hDEADBEEF, 32'h003100B3, 1);
        checkOutput("first_valid", 32'(valid_o), 32'd1);
        checkOutput("legal_no_illegal", 32'(illegal_o), 32'd0);
        applyStimulus(7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'h00, 5'd0, 32'hFFFFFFFF, 32'hFFF30293, 1);
        applyStimulus(7'h13, 5'd8, 5'd9, 5'd0, 3'd5, 7'h20, 5'd7, 32'h0, 32'h4074D413, 1);
        applyStimulus(7'h23, 5'd0, 5'd8, 5'd7, 3'd2, 7'h00, 5'd0, 32'h8, 32'h00742423, 1);
        applyStimulus(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 5'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1);
        applyStimulus(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'h0, 32'h0000006F, 1);
        applyStimulus(7'h37, 5'd10, 5'd31, 5'd17, 3'd6, 7'h7F, 5'd3, 32'h12345000, 32'h12345537, 1);
        waitDrain();

        $display("[TB] full and backpressure");
        pulseReset();
        ready_i = 1'b0;
        applyStimulus(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd1, 32'h00100093, 1);
        applyStimulus(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd2, 32'h00200113, 1);
        applyStimulus(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd3, 32'h00300193, 1);
        applyStimulus(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd4, 32'h00400213, 1);
        checkOutput("full_count", 32'(count_o), 32'd4);
        checkOutput("full_ready", 32'(ready_o), 32'd0);
        fork
            applyStimulus(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd5, 32'h00500293, 1);
            begin
                repeat (2) begin @(posedge clk); #1; end
                checkOutput("held_count", 32'(count_o), 32'd4);
                ready_i = 1'b1;
                @(posedge clk); #1;
                checkOutput("no_bypass_count", 32'(count_o), 32'd3);
            end
        join
        waitDrain();

        $display("[TB] simultaneous push and pop");
        ready_i = 1'b0;
        applyStimulus(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 5'd0, 32'h0, 32'h402081B3, 1);
        applyStimulus(7'h17, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'h00001000, 32'h00001297, 1);
        checkOutput("pair_count", 32'(count_o), 32'd2);
        ready_i = 1'b1;
        applyStimulus(7'h03, 5'd6, 5'd2, 5'd0, 3'd2, 7'h00, 5'd0, 32'd12, 32'h00C12303, 1);
        checkOutput("pushpop_count", 32'(count_o), 32'd2);
        waitDrain();

        $display("[TB] illegal opcode");
        applyStimulus(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 5'd0, 32'h0, 32'h0, 0);
        checkOutput("illegal_pulse", 32'(illegal_o), 32'd1);
`ifdef INSN_ENCODER_ILLEGAL_NOP_EN
        checkOutput("illegal_count", 32'(count_o), 32'd1);
`else
        checkOutput("illegal_count", 32'(count_o), 32'd0);
`endif
        @(posedge clk); #1;
        checkOutput("illegal_single", 32'(illegal_o), 32'd0);
        applyStimulus(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd5, 32'h00500293, 1);
        waitDrain();

        $display("[TB] reset mid-stream");
        ready_i = 1'b0;
        applyStimulus(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd1, 32'h00100093, 1);
        applyStimulus(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd2, 32'h00200113, 1);
        applyStimulus(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'd3, 32'h00300193, 1);
        checkOutput("queued_count", 32'(count_o), 32'd3);
        pulseReset();
        ready_i = 1'b1;
        applyStimulus(7'h37, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 5'd0, 32'h12345000, 32'h12345537, 1);
        waitDrain();

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
